// File: rtl/sm4_key_schedule.sv
// SM4 key expansion: loads a 128-bit master key, derives 32 round keys (one per clock)
// into a zeroizable register file and serves them by index in encrypt or decrypt order.

module sbox_32b (
  input  logic [31:0] i_din,
  output logic [31:0] o_dout
);
  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  assign o_dout = {SBOX[i_din[31:24]], SBOX[i_din[23:16]], SBOX[i_din[15:8]], SBOX[i_din[7:0]]};
endmodule

module sm4_key_schedule #(
  parameter int NUM_RK     = 32,
  parameter bit RK_OUT_REG = 1'b1
) (
  input  logic         CLK_i,
  input  logic         RST_N_i,
  input  logic [127:0] MK_i,
  input  logic         MK_VALID_i,
  output logic         MK_READY_o,
  input  logic [4:0]   RK_IDX_i,
  input  logic         DECRYPT_i,
  output logic [31:0]  RK_o,
  output logic         KEYS_VALID_o,
  output logic         BUSY_o,
  output logic         DONE_o,
  output logic [1:0]   DBG_STATE_o
);
  // Handshake: a master key is taken on any rising edge where MK_VALID_i and
  // MK_READY_o are both high; MK_VALID_i is ignored while expanding (no queuing).

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_READY  = 2'd2
  } state_t;

  localparam logic [4:0]  LAST_IDX = 5'(NUM_RK - 1);
  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_last;
  logic [4:0]  r_cnt;
  logic [31:0] r_k0, r_k1, r_k2, r_k3;
  logic [31:0] r_rk_mem [NUM_RK];
  logic        r_done;
  logic [7:0]  w_ck_base;
  logic [31:0] w_ck;
  logic [31:0] w_sbox_in;
  logic [31:0] w_tau;
  logic [31:0] w_rk;
  logic [4:0]  w_rd_addr;

  function automatic logic [7:0] ck_byte(input logic [7:0] n);
    return n * 8'd7;
  endfunction

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    MK_READY_o   = 1'b0;
    BUSY_o       = 1'b0;
    KEYS_VALID_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        MK_READY_o = 1'b1;
        w_accept   = MK_VALID_i;
        if (MK_VALID_i) w_state_nxt = S_EXPAND;
      end
      S_EXPAND: begin
        BUSY_o = 1'b1;
        w_last = (r_cnt == LAST_IDX);
        if (w_last) w_state_nxt = S_READY;
      end
      S_READY: begin
        MK_READY_o   = 1'b1;
        KEYS_VALID_o = 1'b1;
        w_accept     = MK_VALID_i;
        if (MK_VALID_i) w_state_nxt = S_EXPAND;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign DBG_STATE_o = r_state;
  assign DONE_o      = r_done;

  // CK[i] byte j = (4i+j)*7 mod 256, built from the round counter instead of a table.
  assign w_ck_base = {1'b0, r_cnt, 2'b00};
  assign w_ck = {ck_byte(w_ck_base),         ck_byte(w_ck_base + 8'd1),
                 ck_byte(w_ck_base + 8'd2),  ck_byte(w_ck_base + 8'd3)};

  assign w_sbox_in = r_k1 ^ r_k2 ^ r_k3 ^ w_ck;

  sbox_32b u_sbox (
    .i_din  (w_sbox_in),
    .o_dout (w_tau)
  );

  assign w_rk = r_k0 ^ w_tau ^ {w_tau[18:0], w_tau[31:19]} ^ {w_tau[8:0], w_tau[31:9]};

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      r_k0   <= '0;
      r_k1   <= '0;
      r_k2   <= '0;
      r_k3   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_k0  <= MK_i[127:96] ^ FK0;
        r_k1  <= MK_i[95:64]  ^ FK1;
        r_k2  <= MK_i[63:32]  ^ FK2;
        r_k3  <= MK_i[31:0]   ^ FK3;
        r_cnt <= '0;
      end else if (r_state == S_EXPAND) begin
        r_k0  <= r_k1;
        r_k1  <= r_k2;
        r_k2  <= r_k3;
        r_k3  <= w_rk;
        // Rolls over to 0 exactly as the FSM leaves EXPAND.
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      for (int n = 0; n < NUM_RK; n++) r_rk_mem[n] <= '0;
    end else if (r_state == S_EXPAND) begin
      r_rk_mem[r_cnt] <= w_rk;
    end
  end

  assign w_rd_addr = DECRYPT_i ? (LAST_IDX - RK_IDX_i) : RK_IDX_i;

  generate
    if (RK_OUT_REG) begin : g_rk_reg
      logic [31:0] r_rk;
      always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) r_rk <= '0;
        else          r_rk <= r_rk_mem[w_rd_addr];
      end
      assign RK_o = r_rk;
    end else begin : g_rk_comb
      assign RK_o = r_rk_mem[w_rd_addr];
    end
  endgenerate

endmodule

// File: tb/tb_sm4_key_schedule.sv
// Bench for sm4_key_schedule: handshake/latency checks, fixed vectors, and a reference
// key-expansion model feeding an expected-value queue for full round-key sweeps.

module tb_sm4_key_schedule;
  logic         clk;
  logic         rst_n;
  logic [127:0] mk;
  logic         mk_valid;
  logic         mk_ready;
  logic [4:0]   rk_idx;
  logic         decrypt;
  logic [31:0]  rk;
  logic         keys_valid;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rk[32];

  localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KEY2    = 128'h00112233445566778899AABBCCDDEEFF;

  localparam logic [7:0] SBOX_T [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  sm4_key_schedule #(.NUM_RK(32), .RK_OUT_REG(1'b1)) dut (
    .CLK_i        (clk),
    .RST_N_i      (rst_n),
    .MK_i         (mk),
    .MK_VALID_i   (mk_valid),
    .MK_READY_o   (mk_ready),
    .RK_IDX_i     (rk_idx),
    .DECRYPT_i    (decrypt),
    .RK_o         (rk),
    .KEYS_VALID_o (keys_valid),
    .BUSY_o       (busy),
    .DONE_o       (done),
    .DBG_STATE_o  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // reference model: straight textbook recurrence K[i+4] = K[i] ^ T'(K[i+1]^K[i+2]^K[i+3]^CK[i])
  function automatic void model_ks(input logic [127:0] key);
    logic [31:0] k[36];
    logic [31:0] ck, t, b;
    k[0] = key[127:96] ^ 32'hA3B1BAC6;
    k[1] = key[95:64]  ^ 32'h56AA3350;
    k[2] = key[63:32]  ^ 32'h677D9197;
    k[3] = key[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      t = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck;
      for (int j = 0; j < 4; j++) b[31-8*j -: 8] = SBOX_T[t[31-8*j -: 8]];
      k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
      exp_rk[i] = k[i+4];
    end
  endfunction

  // drivers
  task automatic wait_done(output int n, output int rdy_hi);
    n = 0;
    rdy_hi = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (mk_ready) rdy_hi++;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    int n, rdy_hi;
    @(negedge clk);
    mk = key;
    mk_valid = 1'b1;
    chk("accept_ready", mk_ready, 1);
    @(negedge clk);
    mk_valid = 1'b0;
    chk("expand_busy", busy, 1);
    chk("expand_not_ready", mk_ready, 0);
    chk("expand_kv_low", keys_valid, 0);
    chk("expand_state", dbg_state, 1);
    wait_done(n, rdy_hi);
    chk("done_latency", n, 32);
    chk("ready_low_during_expand", rdy_hi, 0);
    chk("kv_at_done", keys_valid, 1);
    chk("ready_at_done", mk_ready, 1);
    chk("ready_state", dbg_state, 2);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic rd_one(input logic [4:0] idx, input bit dec, output logic [31:0] v);
    @(negedge clk);
    rk_idx = idx;
    decrypt = dec;
    @(negedge clk);
    v = rk;
  endtask

  // scoreboard sweep: expected key pushed when the index is driven, popped one cycle later
  task automatic sweep(input bit dec);
    logic [31:0] e;
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      if (k > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("rk_sweep_%s_%0d", dec ? "dec" : "enc", k - 1), rk, e);
      end
      if (k < 32) begin
        rk_idx = 5'(k);
        decrypt = dec;
        exp_q.push_back(exp_rk[dec ? 31 - k : k]);
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    int n, rdy_hi, done_seen;
    rst_n = 1'b0;
    mk = '0;
    mk_valid = 1'b0;
    rk_idx = '0;
    decrypt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", mk_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_kv", keys_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_rk", rk, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    // standard vector, fixed reads
    load_key(STD_KEY);
    rd_one(5'd0, 1'b0, v);  chk("std_enc_0", v, 32'hF12186F9);
    rd_one(5'd1, 1'b0, v);  chk("std_enc_1", v, 32'h41662B61);
    rd_one(5'd31, 1'b0, v); chk("std_enc_31", v, 32'h9124A012);
    rd_one(5'd0, 1'b1, v);  chk("std_dec_0", v, 32'h9124A012);
    rd_one(5'd31, 1'b1, v); chk("std_dec_31", v, 32'hF12186F9);
    @(negedge clk);
    rk_idx = 5'd0;
    decrypt = 1'b1;
    #1 chk("rd_lag_hold", rk, 32'hF12186F9);
    @(negedge clk);
    chk("rd_lag_update", rk, 32'h9124A012);
    model_ks(STD_KEY);
    sweep(1'b0);
    sweep(1'b1);

    // backpressure: second key held valid through the whole expansion
    @(negedge clk);
    mk = STD_KEY;
    mk_valid = 1'b1;
    @(negedge clk);
    mk = KEY2;
    chk("bp_busy", busy, 1);
    wait_done(n, rdy_hi);
    chk("bp_first_latency", n, 32);
    chk("bp_ready_low", rdy_hi, 0);
    chk("bp_kv_high", keys_valid, 1);
    @(negedge clk);
    mk_valid = 1'b0;
    chk("bp_kv_drop", keys_valid, 0);
    chk("bp_rebusy", busy, 1);
    wait_done(n, rdy_hi);
    chk("bp_second_latency", n, 32);
    model_ks(KEY2);
    sweep(1'b0);

    // asynchronous reset in the middle of expansion
    @(negedge clk);
    mk = STD_KEY;
    mk_valid = 1'b1;
    @(negedge clk);
    mk_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", mk_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_kv", keys_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rk", rk, 0);
    chk("mid_rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("mid_rst_no_done", done_seen, 0);
    rd_one(5'd0, 1'b0, v);  chk("mid_rst_zeroized_0", v, 0);
    rd_one(5'd14, 1'b0, v); chk("mid_rst_zeroized_14", v, 0);
    load_key(STD_KEY);
    rd_one(5'd0, 1'b0, v);  chk("post_rst_rk0", v, 32'hF12186F9);

    // all-zero key
    load_key('0);
    model_ks('0);
    sweep(1'b0);

    // random keys
    for (int r = 0; r < 1000; r++) begin
      logic [127:0] key;
      key = {32'($urandom_range(32'hFFFF_FFFF, 0)), 32'($urandom_range(32'hFFFF_FFFF, 0)),
             32'($urandom_range(32'hFFFF_FFFF, 0)), 32'($urandom_range(32'hFFFF_FFFF, 0))};
      load_key(key);
      model_ks(key);
      sweep(1'($urandom_range(1, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
